// File: rtl/prod_accum.sv
// Frame accumulator for the multiplier product stream (MAC tail).
// It sums acc_len unsigned products, saturating at ACC_W bits, and presents the sum on a valid/ready port.
module prod_accum #(
    parameter int IN_W    = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [LEN_W-1:0] acc_len,
    input  logic [IN_W-1:0]  prod_in,
    input  logic             prod_vld,
    output logic             prod_rdy,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_vld,
    input  logic             sum_rdy,
    output logic             ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX   = '1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_vld_q, sum_vld_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q;

    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt_inc;
    logic [ACC_W:0]   acc_ext;
    logic             sat;
    logic [ACC_W-1:0] acc_sat;

    // rdy_q holds prod_rdy low until the first edge after reset release
    assign prod_rdy = rdy_q & (state_q != S_DONE);
    assign sum_out  = sum_q;
    assign sum_vld  = sum_vld_q;
    assign ovf      = ovf_q;

    always_comb begin
        accept  = prod_vld & prod_rdy;
        len_eff = (acc_len == '0 || acc_len > MAX_LEN_L) ? MAX_LEN_L : acc_len;
        cnt_inc = cnt_q + 1'b1;
        acc_ext = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
        sat     = acc_ext[ACC_W];
        acc_sat = sat ? ACC_MAX : acc_ext[ACC_W-1:0];

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sum_d     = sum_q;
        sum_vld_d = sum_vld_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d = ACC_W'(prod_in);
                    cnt_d = LEN_W'(1);
                    len_d = len_eff;
                    ovf_d = 1'b0;
                    if (len_eff == LEN_W'(1)) begin
                        state_d   = S_DONE;
                        sum_d     = ACC_W'(prod_in);
                        sum_vld_d = 1'b1;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d = acc_sat;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sat;
                    if (cnt_inc == len_q) begin
                        state_d   = S_DONE;
                        sum_d     = acc_sat;
                        sum_vld_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (sum_rdy) begin
                    state_d   = S_IDLE;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sum_vld_d = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything in flight, including a same-cycle product or handshake
        if (clr) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            sum_vld_d = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            ovf_q     <= ovf_d;
            rdy_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a table of frames plus hand sequences for reset, backpressure and abort.
// A second instance with ACC_W=17 shares all inputs and exercises saturation.
module tb_prod_accum;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic [4:0]  acc_len;
    logic [15:0] prod_in;
    logic        prod_vld;
    logic        sum_rdy;
    logic        prod_rdy,   prod_rdy17;
    logic [23:0] sum_out;
    logic [16:0] sum_out17;
    logic        sum_vld,    sum_vld17;
    logic        ovf,        ovf17;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    prod_accum dut (
        .clk(clk), .rstn(rstn), .clr(clr), .acc_len(acc_len), .prod_in(prod_in),
        .prod_vld(prod_vld), .prod_rdy(prod_rdy), .sum_out(sum_out), .sum_vld(sum_vld),
        .sum_rdy(sum_rdy), .ovf(ovf)
    );

    prod_accum #(.ACC_W(17)) dut17 (
        .clk(clk), .rstn(rstn), .clr(clr), .acc_len(acc_len), .prod_in(prod_in),
        .prod_vld(prod_vld), .prod_rdy(prod_rdy17), .sum_out(sum_out17), .sum_vld(sum_vld17),
        .sum_rdy(sum_rdy), .ovf(ovf17)
    );

    typedef struct {
        logic [4:0]  len;
        bit          chg;      // rewrite acc_len after the first accept
        logic [4:0]  new_len;
        int          n;        // products actually fed
        int          base;
        int          step;
        int          last;     // value of the final product
        logic [23:0] exp_sum;
        logic        exp_ovf;
        logic [16:0] exp_sum17;
        logic        exp_ovf17;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Feed one frame back to back with sum_rdy held high and check the result and the DONE bubble
    task automatic run_frame(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        sum_rdy = 1'b1;
        acc_len = v.len;
        for (int i = 0; i < v.n; i++) begin
            prod_vld = 1'b1;
            prod_in  = (i == v.n - 1) ? 16'(v.last) : 16'(v.base + i * v.step);
            if (i == v.n - 1) chk({tag, " vld_before_last"}, {31'd0, sum_vld}, 32'd0);
            step();
            if (i == 0 && v.chg) acc_len = v.new_len;
        end
        prod_vld = 1'b0;
        chk({tag, " sum_vld"},   {31'd0, sum_vld},   32'd1);
        chk({tag, " sum_out"},   {8'd0, sum_out},    {8'd0, v.exp_sum});
        chk({tag, " ovf"},       {31'd0, ovf},       {31'd0, v.exp_ovf});
        chk({tag, " sum_out17"}, {15'd0, sum_out17}, {15'd0, v.exp_sum17});
        chk({tag, " ovf17"},     {31'd0, ovf17},     {31'd0, v.exp_ovf17});
        chk({tag, " rdy_done"},  {31'd0, prod_rdy},  32'd0);
        step();
        chk({tag, " vld_after"}, {31'd0, sum_vld},   32'd0);
        chk({tag, " rdy_after"}, {31'd0, prod_rdy},  32'd1);
    endtask

    task automatic feed4(input int a, input int b, input int c, input int d);
        int p[4];
        p = '{a, b, c, d};
        acc_len = 5'd4;
        for (int i = 0; i < 4; i++) begin
            prod_vld = 1'b1;
            prod_in  = 16'(p[i]);
            step();
        end
        prod_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        len   chg  nlen  n   base   step last   sum24    o  sum17    o
        vecs[0] = '{5'd4,  0, 5'd0, 4,  10,    10,  40,    24'd100,     0, 17'd100,    0};
        vecs[1] = '{5'd3,  0, 5'd0, 3,  65535, 0,   65535, 24'd196605,  0, 17'd131071, 1};
        vecs[2] = '{5'd3,  0, 5'd0, 3,  1,     0,   1,     24'd3,       0, 17'd3,      0};
        vecs[3] = '{5'd0,  0, 5'd0, 16, 1,     1,   16,    24'd136,     0, 17'd136,    0};
        vecs[4] = '{5'd1,  0, 5'd0, 1,  0,     0,   7,     24'd7,       0, 17'd7,      0};
        vecs[5] = '{5'd20, 0, 5'd0, 16, 100,   0,   100,   24'd1600,    0, 17'd1600,   0};
        vecs[6] = '{5'd4,  1, 5'd2, 4,  5,     1,   8,     24'd26,      0, 17'd26,     0};
        vecs[7] = '{5'd2,  0, 5'd0, 2,  65535, 0,   65535, 24'd131070,  0, 17'd131070, 0};
        vecs[8] = '{5'd3,  0, 5'd0, 3,  65535, 0,   2,     24'd131072,  0, 17'd131071, 1};
        vecs[9] = '{5'd4,  0, 5'd0, 4,  65535, 0,   65535, 24'd262140,  0, 17'd131071, 1};

        // Reset with a product pending
        rstn = 1'b0; clr = 1'b0; acc_len = 5'd4; prod_in = 16'd5; prod_vld = 1'b1; sum_rdy = 1'b1;
        step(); step();
        chk("rst sum_vld",  {31'd0, sum_vld},  32'd0);
        chk("rst sum_out",  {8'd0, sum_out},   32'd0);
        chk("rst ovf",      {31'd0, ovf},      32'd0);
        chk("rst prod_rdy", {31'd0, prod_rdy}, 32'd0);
        prod_vld = 1'b0;
        rstn = 1'b1;
        #1 chk("rel prod_rdy_pre", {31'd0, prod_rdy}, 32'd0);
        step();
        chk("rel prod_rdy", {31'd0, prod_rdy}, 32'd1);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

        // Backpressure: the sum is held and products are refused while DONE waits
        sum_rdy = 1'b0;
        feed4(10, 20, 30, 40);
        prod_vld = 1'b1; prod_in = 16'd999;
        for (int i = 0; i < 5; i++) begin
            chk("bp sum_vld",  {31'd0, sum_vld},  32'd1);
            chk("bp sum_out",  {8'd0, sum_out},   32'd100);
            chk("bp prod_rdy", {31'd0, prod_rdy}, 32'd0);
            step();
        end
        prod_vld = 1'b0;
        sum_rdy = 1'b1;
        step();
        chk("bp released vld", {31'd0, sum_vld},  32'd0);
        chk("bp released rdy", {31'd0, prod_rdy}, 32'd1);
        run_frame(vecs[2], 100);

        // Abort after 2 of 4 products, with a product presented alongside clr
        acc_len = 5'd4;
        prod_vld = 1'b1; prod_in = 16'd50; step();
        prod_in = 16'd60; step();
        clr = 1'b1; prod_in = 16'd70; step();
        clr = 1'b0; prod_vld = 1'b0;
        chk("clr sum_vld",  {31'd0, sum_vld},  32'd0);
        chk("clr prod_rdy", {31'd0, prod_rdy}, 32'd1);
        step();
        chk("clr no_sum", {31'd0, sum_vld}, 32'd0);
        run_frame('{5'd4, 0, 5'd0, 4, 1, 1, 4, 24'd10, 0, 17'd10, 0}, 101);

        // Abort while a sum is pending discards it even with sum_rdy high
        sum_rdy = 1'b0;
        feed4(1, 1, 1, 1);
        chk("clr_done pending", {31'd0, sum_vld}, 32'd1);
        clr = 1'b1; sum_rdy = 1'b1; step();
        clr = 1'b0;
        chk("clr_done vld", {31'd0, sum_vld}, 32'd0);
        run_frame('{5'd4, 0, 5'd0, 4, 2, 2, 8, 24'd20, 0, 17'd20, 0}, 102);

        // Reset mid-frame loses the partial frame
        acc_len = 5'd4;
        prod_vld = 1'b1; prod_in = 16'd500; step(); step();
        prod_vld = 1'b0;
        rstn = 1'b0;
        #1 chk("midrst prod_rdy", {31'd0, prod_rdy}, 32'd0);
        step();
        rstn = 1'b1;
        step();
        run_frame('{5'd4, 0, 5'd0, 4, 3, 0, 3, 24'd12, 0, 17'd12, 0}, 103);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
